// File: rtl/round_ctrl_if.sv
// round_ctrl_if: request, mask-unit and result signals of the rounding
// controller. The master side issues requests and supplies the
// combinational mask-unit results. The slave side is round_ctrl.
interface round_ctrl_if #(
  parameter int W = 64
);
  // request handshake
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sig;
  logic [12:0]  in_sh;
  logic         in_sticky;
  logic [1:0]   in_mode;
  logic         in_sign;
  // external mask unit
  logic [12:0]  mask_sh;
  logic [W-1:0] mask_v;
  logic [W-1:0] mask_w;
  // result handshake
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sig;
  logic         out_inexact;
  logic         out_carry;

  modport master (
    output in_valid, in_sig, in_sh, in_sticky, in_mode, in_sign,
    output mask_v, mask_w, out_ready,
    input  in_ready, mask_sh, out_valid, out_sig, out_inexact, out_carry
  );

  modport slave (
    input  in_valid, in_sig, in_sh, in_sticky, in_mode, in_sign,
    input  mask_v, mask_w, out_ready,
    output in_ready, mask_sh, out_valid, out_sig, out_inexact, out_carry
  );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: rounds a significand at the position marked by an external
// mask unit. The flow is IDLE -> MASK -> ROUND -> DONE.
// The result appears three cycles after the accepting cycle, so one
// result is produced every four cycles.
// Optional feature: define ROUND_CTRL_STATS_EN to add a 16-bit
// saturating count of inexact results on port inexact_cnt.
module round_ctrl #(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  round_ctrl_if.slave       bus
`ifdef ROUND_CTRL_STATS_EN
  ,
  output logic [15:0]       inexact_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MASK, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] sig_q, sig_d;
  logic [12:0]  mask_sh_q, mask_sh_d;
  logic         sticky_q, sticky_d;
  logic [1:0]   mode_q, mode_d;
  logic         sign_q, sign_d;
  logic [W-1:0] v_q, v_d;
  logic [W-1:0] w_q, w_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_sig_q, out_sig_d;
  logic         out_inexact_q, out_inexact_d;
  logic         out_carry_q, out_carry_d;

  // rounding datapath signals, all derived from registered operands
  logic [W-1:0] kept, lost, ulp, half;
  logic         guard, rest, lsb, inc_mode, inc;
  logic [W:0]   sum;
  logic [W-1:0] round_sig;
  logic         round_inexact, round_carry;

  // Rounding arithmetic on the registered sig and the registered mask v
  always_comb begin
    kept  = sig_q & v_q;
    lost  = sig_q & ~v_q;
    ulp   = v_q & ~(v_q << 1);
    half  = ulp >> 1;
    guard = |(lost & half);
    rest  = (|(lost & ~half)) | sticky_q;
    lsb   = |(kept & ulp);
    case (mode_q)
      2'b00:   inc_mode = guard & (rest | lsb);
      2'b01:   inc_mode = 1'b0;
      2'b10:   inc_mode = ~sign_q & (guard | rest);
      default: inc_mode = sign_q & (guard | rest);
    endcase
    // An empty mask has no ulp, so nothing is kept and nothing can round up
    inc = inc_mode & (|v_q);
    sum = {1'b0, kept} + (inc ? {1'b0, ulp} : {(W+1){1'b0}});
    round_carry = sum[W];
    round_sig   = round_carry ? sum[W:1] : sum[W-1:0];
    if (v_q == '0) begin
      round_sig     = '0;
      round_inexact = (|sig_q) | sticky_q;
    end else begin
      round_inexact = guard | rest;
    end
    // w marks left-shift fill bits that are passed through unchanged
    round_sig = round_sig | (sig_q & w_q);
  end

  // Next-state and registered-output logic of the controller FSM
  always_comb begin
    state_d       = state_q;
    sig_d         = sig_q;
    mask_sh_d     = mask_sh_q;
    sticky_d      = sticky_q;
    mode_d        = mode_q;
    sign_d        = sign_q;
    v_d           = v_q;
    w_d           = w_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_sig_d     = out_sig_q;
    out_inexact_d = out_inexact_q;
    out_carry_d   = out_carry_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sig_d      = bus.in_sig;
          mask_sh_d  = bus.in_sh;
          sticky_d   = bus.in_sticky;
          mode_d     = bus.in_mode;
          sign_d     = bus.in_sign;
          in_ready_d = 1'b0;
          state_d    = MASK;
        end
      end
      MASK: begin
        // mask_sh has been stable for this whole cycle
        v_d     = bus.mask_v;
        w_d     = bus.mask_w;
        state_d = ROUND;
      end
      ROUND: begin
        out_sig_d     = round_sig;
        out_inexact_d = round_inexact;
        out_carry_d   = round_carry;
        out_valid_d   = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          mask_sh_d   = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sig_q         <= '0;
      mask_sh_q     <= '0;
      sticky_q      <= 1'b0;
      mode_q        <= 2'b00;
      sign_q        <= 1'b0;
      v_q           <= '0;
      w_q           <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_sig_q     <= '0;
      out_inexact_q <= 1'b0;
      out_carry_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sig_q         <= sig_d;
      mask_sh_q     <= mask_sh_d;
      sticky_q      <= sticky_d;
      mode_q        <= mode_d;
      sign_q        <= sign_d;
      v_q           <= v_d;
      w_q           <= w_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sig_q     <= out_sig_d;
      out_inexact_q <= out_inexact_d;
      out_carry_q   <= out_carry_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mask_sh     = mask_sh_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sig     = out_sig_q;
  assign bus.out_inexact = out_inexact_q;
  assign bus.out_carry   = out_carry_q;

`ifdef ROUND_CTRL_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Count inexact results at each completed output handshake, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DONE && bus.out_ready && out_inexact_q && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  // Statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign inexact_cnt = cnt_q;
`endif

endmodule
